power_integrator: RTL and testbench

Downstream consumer of the complex-power stage. It accumulates unsigned power samples over a programmable number of valid samples and emits one integrated spectrum-bin power per frame. It saturates instead of wrapping, and supports a sync pulse to realign frames to an external event. Its output feeds the readout/BRAM writer.

---
 rtl/power_integrator.sv | 129 ++++++++++++
 tb/tb_power_integrator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/power_integrator.sv
`default_nettype none
// ============================================================================
//  Module   : power_integrator
//  Purpose  : Integrates unsigned power samples over a programmable number of
//             valid samples and emits one saturated bin power per frame.
//             A sync pulse aborts the open frame and realigns framing.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   system clock, all logic on posedge
//    rst        in   asynchronous active-low reset
//    din        in   unsigned power sample (DIN_WIDTH)
//    din_valid  in   qualifies din, one sample per cycle
//    acc_len    in   samples per frame, captured at frame start (0 means 1)
//    sync       in   single-cycle pulse, discards the open frame
//    dout       out  integrated power of the completed frame (DOUT_WIDTH)
//    dout_valid out  one-cycle strobe for dout
//    dout_sat   out  high if the reported frame saturated
//    busy       out  high while a frame holds at least one sample
// ============================================================================
module power_integrator #(
  parameter int DIN_WIDTH     = 33,
  parameter int ACC_LEN_WIDTH = 16,
  parameter int DOUT_WIDTH    = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DIN_WIDTH-1:0]     din,
  input  logic                     din_valid,
  input  logic [ACC_LEN_WIDTH-1:0] acc_len,
  input  logic                     sync,
  output logic [DOUT_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic                     dout_sat,
  output logic                     busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [ACC_LEN_WIDTH-1:0] LEN_ONE = ACC_LEN_WIDTH'(1);

  state_t                   state;
  logic [DOUT_WIDTH-1:0]    acc;
  logic [ACC_LEN_WIDTH-1:0] cnt;
  logic [ACC_LEN_WIDTH-1:0] len_q;
  logic                     sat;

  logic                     frame_start;
  logic [ACC_LEN_WIDTH-1:0] len_new;
  logic [ACC_LEN_WIDTH-1:0] eff_len;
  logic [DOUT_WIDTH-1:0]    base_acc;
  logic [ACC_LEN_WIDTH-1:0] base_cnt;
  logic                     base_sat;
  logic [DOUT_WIDTH:0]      sum;
  logic                     carry;
  logic [DOUT_WIDTH-1:0]    next_acc;
  logic                     next_sat;
  logic                     last;

  // A new frame begins either on the first sample seen in IDLE or on sync.
  // In both cases the sample of this cycle (if any) is accumulated on top of
  // a cleared frame using the freshly captured length, so sync and frame
  // completion on the same cycle resolve naturally in favour of sync.
  always_comb begin
    frame_start = sync | (din_valid & (state == IDLE));
    len_new     = (acc_len == '0) ? LEN_ONE : acc_len;
    eff_len     = frame_start ? len_new : len_q;
    base_acc    = frame_start ? '0 : acc;
    base_cnt    = frame_start ? '0 : cnt;
    base_sat    = frame_start ? 1'b0 : sat;
    // One extra bit catches the carry-out that signals saturation.
    sum         = {1'b0, base_acc} + (DOUT_WIDTH+1)'(din);
    carry       = sum[DOUT_WIDTH];
    next_acc    = carry ? '1 : sum[DOUT_WIDTH-1:0];
    next_sat    = base_sat | carry;
    last        = din_valid & (base_cnt == (eff_len - LEN_ONE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      len_q      <= LEN_ONE;
      sat        <= 1'b0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sat   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (frame_start) begin
        len_q <= len_new;
      end
      if (din_valid) begin
        if (last) begin
          // Frame complete: publish and clear so a sample on the very next
          // cycle opens a fresh frame without loss.
          dout       <= next_acc;
          dout_sat   <= next_sat;
          dout_valid <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          sat        <= 1'b0;
          state      <= IDLE;
          busy       <= 1'b0;
        end else begin
          acc   <= next_acc;
          cnt   <= base_cnt + LEN_ONE;
          sat   <= next_sat;
          state <= ACC;
          busy  <= 1'b1;
        end
      end else if (sync) begin
        // Sync with no sample: drop the partial frame and wait in IDLE.
        acc   <= '0;
        cnt   <= '0;
        sat   <= 1'b0;
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_power_integrator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_power_integrator
//  Purpose  : Self-checking bench for power_integrator. A frame-level model
//             (list of samples per frame, plain summation, clamp) predicts
//             each strobe; a monitor compares DUT outputs every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_power_integrator;

  localparam int DIN_W  = 33;
  localparam int LEN_W  = 16;
  localparam int DOUT_W = 34;
  localparam logic [DIN_W-1:0] MAXD = {DIN_W{1'b1}};
  localparam longint unsigned MAXO = (64'd1 << DOUT_W) - 64'd1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIN_W-1:0]  din = '0;
  logic              din_valid = 1'b0;
  logic [LEN_W-1:0]  acc_len = '0;
  logic              sync = 1'b0;
  logic [DOUT_W-1:0] dout;
  logic              dout_valid;
  logic              dout_sat;
  logic              busy;

  power_integrator #(
    .DIN_WIDTH    (DIN_W),
    .ACC_LEN_WIDTH(LEN_W),
    .DOUT_WIDTH   (DOUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .acc_len   (acc_len),
    .sync      (sync),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_sat  (dout_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned sum;
    bit              sat;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Frame-level reference model state.
  longint unsigned frame[$];
  int              mlen = 1;
  bit              in_frame = 1'b0;
  bit              exp_strobe = 1'b0;
  bit              exp_busy = 1'b0;
  longint unsigned hold_dout = 0;
  bit              hold_sat = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Advances the model by one clock of input.
  task automatic model(input bit v, input logic [DIN_W-1:0] d, input bit s, input logic [LEN_W-1:0] l);
    longint unsigned total;
    exp_t e;
    exp_strobe = 1'b0;
    if (s && !v) begin
      frame.delete();
      in_frame = 1'b0;
    end
    if (v) begin
      if (s || !in_frame) begin
        frame.delete();
        mlen     = (l == 0) ? 1 : int'(l);
        in_frame = 1'b1;
      end
      frame.push_back(longint'(d));
      if (frame.size() == mlen) begin
        total = 0;
        foreach (frame[i]) total += frame[i];
        e.sat = (total > MAXO);
        e.sum = e.sat ? MAXO : total;
        exp_q.push_back(e);
        exp_strobe = 1'b1;
        frame.delete();
        in_frame = 1'b0;
      end
    end
    exp_busy = in_frame;
  endtask

  task automatic cyc(input bit v, input logic [DIN_W-1:0] d, input bit s, input logic [LEN_W-1:0] l);
    @(negedge clk);
    din_valid = v;
    din       = d;
    sync      = s;
    acc_len   = l;
    model(v, d, s, l);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, acc_len);
  endtask

  // Asserts reset between the last drive and the next edge, so any sample
  // just presented is never captured.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    frame.delete();
    in_frame   = 1'b0;
    exp_strobe = 1'b0;
    exp_busy   = 1'b0;
    exp_q.delete();
    hold_dout  = 0;
    hold_sat   = 1'b0;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_sat", dout_sat, 0);
    chk("rst_busy", busy, 0);
    idle(3);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle, pops the scoreboard on strobes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("dout_valid", dout_valid, exp_strobe);
      if (dout_valid || exp_strobe) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty actual=strobe expected=none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          hold_dout = e.sum;
          hold_sat  = e.sat;
        end
      end
      chk("dout", dout, hold_dout);
      chk("dout_sat", dout_sat, hold_sat);
      chk("busy", busy, exp_busy);
    end
  end

  initial begin
    logic [DIN_W-1:0] d;
    logic [LEN_W-1:0] l;
    bit v, s;

    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 1,2,3,4 with length 4
    for (int i = 1; i <= 4; i++) cyc(1'b1, DIN_W'(i), 1'b0, 16'd4);
    idle(2);

    // Gapped frame of length 3
    cyc(1'b1, 33'd5, 1'b0, 16'd3);
    cyc(1'b0, 33'd0, 1'b0, 16'd3);
    cyc(1'b1, 33'd7, 1'b0, 16'd9);   // mid-frame length change ignored
    cyc(1'b0, 33'd0, 1'b0, 16'd3);
    cyc(1'b0, 33'd0, 1'b0, 16'd3);
    cyc(1'b1, 33'd9, 1'b0, 16'd3);
    idle(2);

    // Back-to-back length 2, then length 0 treated as 1
    for (int i = 0; i < 6; i++) cyc(1'b1, 33'd100, 1'b0, 16'd2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'd7, 1'b0, 16'd0);
    idle(2);

    // Saturation then a clean frame
    for (int i = 0; i < 4; i++) cyc(1'b1, MAXD, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 33'd1, 1'b0, 16'd4);
    idle(2);

    // Sync on the 3rd sample, then sync on the 4th sample
    cyc(1'b1, 33'd1, 1'b0, 16'd4);
    cyc(1'b1, 33'd1, 1'b0, 16'd4);
    cyc(1'b1, 33'd9, 1'b1, 16'd4);
    for (int i = 2; i <= 4; i++) cyc(1'b1, DIN_W'(i), 1'b0, 16'd4);
    idle(2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'd1, 1'b0, 16'd4);
    cyc(1'b1, 33'd5, 1'b1, 16'd4);
    for (int i = 6; i <= 8; i++) cyc(1'b1, DIN_W'(i), 1'b0, 16'd4);
    cyc(1'b0, 33'd0, 1'b1, 16'd4);   // sync alone on an idle block
    idle(2);

    // Reset mid-frame, then a pending strobe suppressed by reset
    cyc(1'b1, 33'd6, 1'b0, 16'd4);
    cyc(1'b1, 33'd6, 1'b0, 16'd4);
    async_reset();
    for (int i = 0; i < 2; i++) cyc(1'b1, 33'd6, 1'b0, 16'd2);
    idle(2);
    cyc(1'b1, 33'd5, 1'b0, 16'd1);
    async_reset();
    idle(2);

    // Randomised traffic
    l = 16'd3;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       d = MAXD;
        1:       d = DIN_W'($urandom_range(0, 255));
        default: d = {1'($urandom_range(0, 1)), 32'($urandom)};
      endcase
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: l = 16'd0;
          1: l = 16'd1;
          2: l = 16'd2;
          3: l = 16'd3;
          4: l = 16'd5;
          default: l = 16'd8;
        endcase
      end
      cyc(v, d, s, l);
    end
    idle(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
